// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan receiver: segment patterns,
// anode selects, special digit codes and the frame FSM state type.
package seg_pkg;

  // Active-low cathode patterns, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0   = 4'b1110;
  localparam logic [3:0] AN_D1   = 4'b1101;
  localparam logic [3:0] AN_D2   = 4'b1011;
  localparam logic [3:0] AN_D3   = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;

  localparam logic [3:0] CODE_DASH  = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hD;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational inverse of the seven-segment encoder: cathode pattern to
// 4-bit digit code, with valid low for any pattern the scanner never emits.
module seg7_to_code
  import seg_pkg::*;
(
  input  logic [6:0] cathode,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    code  = CODE_BAD;
    valid = 1'b1;
    unique case (cathode)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_DASH:  code = CODE_DASH;
      SEG_BLANK: code = CODE_BLANK;
      default: begin
        code  = CODE_BAD;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 4-digit seven-segment bus: synchronises,
// qualifies each digit dwell, decodes it and reassembles frames in scan order.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 17
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic        seq_err,
  output logic        stalled
);

  localparam int STAB_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYC - 2);
  localparam logic [CNT_W-1:0]  TMO_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  TMO_PRE  = CNT_W'(TIMEOUT_CYC - 1);

  logic [10:0]       sync1_q, sync2_q, prev_q, dwell_q;
  logic [10:0]       dwell_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              acc_q, acc_d;
  state_t            state_q, state_d;
  logic [1:0]        exp_q, exp_d;
  logic [3:0]        d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
  logic [15:0]       digits_q, digits_d;
  logic              frame_valid_q, frame_valid_d;
  logic              seg_err_q, seg_err_d;
  logic              anode_err_q, anode_err_d;
  logic              seq_err_q, seq_err_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              stalled_q, stalled_d;

  logic [3:0] dw_anode;
  logic [6:0] dw_cathode;
  logic [3:0] code;
  logic       code_valid;
  logic [1:0] idx;
  logic       an_ok, an_blank, good_dwell;

  assign dw_anode   = dwell_q[10:7];
  assign dw_cathode = dwell_q[6:0];

  seg7_to_code u_dec (
    .cathode (dw_cathode),
    .code    (code),
    .valid   (code_valid)
  );

  // Stability filter: a dwell is flagged on the one cycle its run length
  // reaches STABLE_CYC-1 and the sampled value is frozen for the FSM.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    acc_d      = 1'b0;
    if (sync2_q != prev_q) begin
      stab_cnt_d = '0;
    end else begin
      if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
      acc_d = (stab_cnt_q == STAB_PRE);
    end
    dwell_d = acc_d ? sync2_q : dwell_q;
  end

  always_comb begin
    idx      = 2'd0;
    an_ok    = 1'b1;
    an_blank = 1'b0;
    case (dw_anode)
      AN_D0:   idx = 2'd0;
      AN_D1:   idx = 2'd1;
      AN_D2:   idx = 2'd2;
      AN_D3:   idx = 2'd3;
      AN_NONE: begin
        an_ok    = 1'b0;
        an_blank = 1'b1;
      end
      default: an_ok = 1'b0;
    endcase
  end

  assign good_dwell = acc_q && an_ok;

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    d0_d          = d0_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    digits_d      = digits_q;
    frame_valid_d = 1'b0;
    seg_err_d     = 1'b0;
    anode_err_d   = acc_q && !an_ok && !an_blank;
    seq_err_d     = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    stalled_d     = stalled_q;

    if (good_dwell) begin
      tmo_cnt_d = '0;
      stalled_d = 1'b0;
      seg_err_d = !code_valid;
      case (state_q)
        ST_HUNT: begin
          if (idx == 2'd0) begin
            d0_d    = code;
            exp_d   = 2'd1;
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (idx == exp_q) begin
            case (exp_q)
              2'd1: d1_d = code;
              2'd2: d2_d = code;
              default: begin
                // Whole frame lands at once so digits is never partial.
                digits_d      = {code, d2_q, d1_q, d0_q};
                frame_valid_d = 1'b1;
                state_d       = ST_HUNT;
              end
            endcase
            exp_d = exp_q + 2'd1;
          end else begin
            seq_err_d = 1'b1;
            if (idx == 2'd0) begin
              d0_d  = code;
              exp_d = 2'd1;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (tmo_cnt_q != TMO_MAX) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_PRE) begin
        stalled_d = 1'b1;
        state_d   = ST_HUNT;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 11'h7FF;
      sync2_q       <= 11'h7FF;
      prev_q        <= 11'h7FF;
      dwell_q       <= 11'h7FF;
      stab_cnt_q    <= '0;
      acc_q         <= 1'b0;
      state_q       <= ST_HUNT;
      exp_q         <= 2'd0;
      d0_q          <= 4'h0;
      d1_q          <= 4'h0;
      d2_q          <= 4'h0;
      digits_q      <= 16'hFFFF;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
      seq_err_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      stalled_q     <= 1'b0;
    end else begin
      sync1_q       <= {anode, cathode};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      dwell_q       <= dwell_d;
      stab_cnt_q    <= stab_cnt_d;
      acc_q         <= acc_d;
      state_q       <= state_d;
      exp_q         <= exp_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      digits_q      <= digits_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      anode_err_q   <= anode_err_d;
      seq_err_q     <= seq_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stalled_q     <= stalled_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign seg_err     = seg_err_q;
  assign anode_err   = anode_err_q;
  assign seq_err     = seq_err_q;
  assign stalled     = stalled_q;

endmodule
